pool2x2_ctrl: RTL and testbench

Sequencer for the 2x2 max-pooling stage of the CNN accelerator. On a start pulse it walks an input feature map in SRAM and feeds each 2x2 window, one element per cycle, into the 4-deep max-pooling unit (pool_en / pool_din). It then writes each window's maximum (pool_dout) back to output SRAM. It owns all addressing and enables, so the pooling datapath stays purely shift-and-compare.

---
 rtl/pool2x2_ctrl.sv | 131 +++++++++++++
 tb/tb_pool2x2_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_ctrl.sv
// pool2x2_ctrl: sequences a full input map through the 2x2 max-pooling unit.
// Each window costs 6 cycles: 4 READ, 1 SHIFT (last pool_en), 1 WRITE.
// The data path is pure pass-through; only addresses and strobes live here.
module pool2x2_ctrl #(
   parameter int IMG_W    = 64,
   parameter int IMG_H    = 64,
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int IN_BASE  = 0,
   parameter int OUT_BASE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              pool_en,
   output logic [DATA_W-1:0] pool_din,
   input  logic [DATA_W-1:0] pool_dout,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   localparam int WIN_X = IMG_W / 2;
   localparam int WIN_Y = IMG_H / 2;
   localparam int CW    = (WIN_X > 1) ? $clog2(WIN_X) : 1;
   localparam int RW    = (WIN_Y > 1) ? $clog2(WIN_Y) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_SHIFT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   r_q, r_d;
   logic [CW-1:0]   c_q, c_d;
   logic [1:0]      k_q, k_d;
   logic            pool_en_q, pool_en_d;

   logic            last_col;
   logic            last_win;
   logic [ADDR_W-1:0] row_a, col_a, rd_addr_c, wr_addr_c;

   assign last_col = (c_q == CW'(WIN_X - 1));
   assign last_win = last_col && (r_q == RW'(WIN_Y - 1));

   // Address generation; arithmetic is done modulo 2^ADDR_W throughout,
   // which matches truncating the full-width result.
   always_comb begin
      row_a     = ADDR_W'(2 * 32'(r_q) + 32'(k_q[1]));
      col_a     = ADDR_W'(2 * 32'(c_q) + 32'(k_q[0]));
      rd_addr_c = ADDR_W'(IN_BASE) + row_a * ADDR_W'(IMG_W) + col_a;
      wr_addr_c = ADDR_W'(OUT_BASE) + ADDR_W'(r_q) * ADDR_W'(WIN_X) + ADDR_W'(c_q);
   end

   // State, window counters and the pool_en delay flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         r_q       <= '0;
         c_q       <= '0;
         k_q       <= '0;
         pool_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         c_q       <= c_d;
         k_q       <= k_d;
         pool_en_q <= pool_en_d;
      end
   end

   // Next-state and counter sequencing.
   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      c_d       = c_q;
      k_d       = k_q;
      pool_en_d = (state_q == S_READ);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               r_d     = '0;
               c_d     = '0;
               k_d     = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) state_d = S_SHIFT;
         end
         S_SHIFT: state_d = S_WRITE;
         S_WRITE: begin
            k_d = '0;
            if (last_win) begin
               state_d = S_DONE;
            end else begin
               state_d = S_READ;
               if (last_col) begin
                  c_d = '0;
                  r_d = r_q + RW'(1);
               end else begin
                  c_d = c_q + CW'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign rd_en    = (state_q == S_READ);
   assign wr_en    = (state_q == S_WRITE);
   // Addresses are held at zero outside their strobe so idle/reset values are 0.
   assign rd_addr  = rd_en ? rd_addr_c : '0;
   assign wr_addr  = wr_en ? wr_addr_c : '0;
   assign pool_en  = pool_en_q;
   assign pool_din = rd_data;
   assign wr_data  = pool_dout;

endmodule

// File: tb/tb_pool2x2_ctrl.sv
// Bench for pool2x2_ctrl: two instances (4x4 at base 0, 8x2 at 100/200),
// behavioural SRAM and pooling unit, scoreboard queues for reads/writes.
module tb_pool2x2_ctrl;
   localparam int AW = 12;
   localparam int DW = 32;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start_s;
   bit   sel;
   logic signed [DW-1:0] mem [0:255];

   logic a_start, a_busy, a_done, a_rd_en, a_pool_en, a_wr_en;
   logic [AW-1:0] a_rd_addr, a_wr_addr;
   logic [DW-1:0] a_rd_data, a_pool_din, a_pool_dout, a_wr_data;
   logic b_start, b_busy, b_done, b_rd_en, b_pool_en, b_wr_en;
   logic [AW-1:0] b_rd_addr, b_wr_addr;
   logic [DW-1:0] b_rd_data, b_pool_din, b_pool_dout, b_wr_data;

   assign a_start = start_s && !sel;
   assign b_start = start_s && sel;

   pool2x2_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW), .DATA_W(DW), .IN_BASE(0), .OUT_BASE(0)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
      .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
      .pool_en(a_pool_en), .pool_din(a_pool_din), .pool_dout(a_pool_dout),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data));

   pool2x2_ctrl #(.IMG_W(8), .IMG_H(2), .ADDR_W(AW), .DATA_W(DW), .IN_BASE(100), .OUT_BASE(200)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
      .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
      .pool_en(b_pool_en), .pool_din(b_pool_din), .pool_dout(b_pool_dout),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data));

   // SRAM models, read latency 1
   always @(posedge clk) if (a_rd_en) a_rd_data <= mem[a_rd_addr[7:0]];
   always @(posedge clk) if (b_rd_en) b_rd_data <= mem[b_rd_addr[7:0]];

   // Pooling unit models: 4-deep shift register, signed max
   logic signed [DW-1:0] a_preg [4];
   logic signed [DW-1:0] b_preg [4];
   always @(posedge clk) if (a_pool_en) begin
      a_preg[3] <= a_preg[2]; a_preg[2] <= a_preg[1]; a_preg[1] <= a_preg[0]; a_preg[0] <= a_pool_din;
   end
   always @(posedge clk) if (b_pool_en) begin
      b_preg[3] <= b_preg[2]; b_preg[2] <= b_preg[1]; b_preg[1] <= b_preg[0]; b_preg[0] <= b_pool_din;
   end
   always_comb begin
      a_pool_dout = a_preg[0];
      for (int i = 1; i < 4; i++) if (a_preg[i] > $signed(a_pool_dout)) a_pool_dout = a_preg[i];
   end
   always_comb begin
      b_pool_dout = b_preg[0];
      for (int i = 1; i < 4; i++) if (b_preg[i] > $signed(b_pool_dout)) b_pool_dout = b_preg[i];
   end

   logic cur_busy, cur_done, cur_pe, cur_rd_en, cur_wr_en;
   logic [AW-1:0] cur_rd_addr, cur_wr_addr;
   assign cur_busy    = sel ? b_busy    : a_busy;
   assign cur_done    = sel ? b_done    : a_done;
   assign cur_pe      = sel ? b_pool_en : a_pool_en;
   assign cur_rd_en   = sel ? b_rd_en   : a_rd_en;
   assign cur_wr_en   = sel ? b_wr_en   : a_wr_en;
   assign cur_rd_addr = sel ? b_rd_addr : a_rd_addr;
   assign cur_wr_addr = sel ? b_wr_addr : a_wr_addr;

   int n_cmp = 0;
   int n_err = 0;
   logic [AW-1:0] exp_rd_a[$];
   logic [AW-1:0] exp_rd_b[$];
   wr_t exp_wr_a[$];
   wr_t exp_wr_b[$];

   task automatic chk(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: strobe seen with no expected entry (t=%0t)", name, $time);
   endtask

   // Reference: every window in row-major order, reads in (dy,dx) order, max of the four.
   task automatic push_expected(input bit s);
      int w, h, ib, ob, v, mx;
      logic [AW-1:0] ad;
      wr_t e;
      w  = s ? 8 : 4;
      h  = s ? 2 : 4;
      ib = s ? 100 : 0;
      ob = s ? 200 : 0;
      for (int r = 0; r < h / 2; r++)
         for (int c = 0; c < w / 2; c++) begin
            mx = 0;
            for (int dy = 0; dy < 2; dy++)
               for (int dx = 0; dx < 2; dx++) begin
                  ad = AW'(ib + (2 * r + dy) * w + 2 * c + dx);
                  v  = mem[ad[7:0]];
                  if ((dy == 0 && dx == 0) || v > mx) mx = v;
                  if (s) exp_rd_b.push_back(ad); else exp_rd_a.push_back(ad);
               end
            e.addr = AW'(ob + r * (w / 2) + c);
            e.data = mx;
            if (s) exp_wr_b.push_back(e); else exp_wr_a.push_back(e);
         end
   endtask

   // Monitors: pop and compare whenever a DUT strobes rd_en / wr_en
   always @(negedge clk) begin
      logic [AW-1:0] ea;
      wr_t ew;
      if (a_rd_en) begin
         if (exp_rd_a.size() == 0) flag("a_rd");
         else begin ea = exp_rd_a.pop_front(); chk("a_rd_addr", a_rd_addr, ea); end
      end
      if (a_wr_en) begin
         if (exp_wr_a.size() == 0) flag("a_wr");
         else begin
            ew = exp_wr_a.pop_front();
            chk("a_wr_addr", a_wr_addr, ew.addr);
            chk("a_wr_data", longint'($signed(a_wr_data)), longint'($signed(ew.data)));
         end
      end
   end

   always @(negedge clk) begin
      logic [AW-1:0] ea;
      wr_t ew;
      if (b_rd_en) begin
         if (exp_rd_b.size() == 0) flag("b_rd");
         else begin ea = exp_rd_b.pop_front(); chk("b_rd_addr", b_rd_addr, ea); end
      end
      if (b_wr_en) begin
         if (exp_wr_b.size() == 0) flag("b_wr");
         else begin
            ew = exp_wr_b.pop_front();
            chk("b_wr_addr", b_wr_addr, ew.addr);
            chk("b_wr_data", longint'($signed(b_wr_data)), longint'($signed(ew.data)));
         end
      end
   end

   task automatic chk_reset_outs(input string name);
      chk(name, longint'({cur_busy, cur_done, cur_rd_en, cur_pe, cur_wr_en, cur_rd_addr, cur_wr_addr}), 0);
   endtask

   // One pass: start asserted now, sampled at the next edge (edge 0).
   // Cycle n is the interval following edge n-1; returns inside cycle dcyc+1.
   task automatic run_pass(input bit s, input int extra_start, input int rst_at);
      int nwin, dcyc, done_cyc, busy_n, done_n, pe_n;
      nwin     = s ? (8 / 2) * (2 / 2) : (4 / 2) * (4 / 2);
      dcyc     = 6 * nwin + 1;
      done_cyc = 0; busy_n = 0; done_n = 0; pe_n = 0;
      sel      = s;
      push_expected(s);
      start_s = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= dcyc + 1; cyc++) begin
         if (cyc > 1) @(posedge clk);
         #1;
         start_s = (cyc == extra_start);
         if (cyc == rst_at) begin
            rst = 1'b1;
            #1;
            chk_reset_outs("mid_pass_reset_outputs");
            rst = 1'b0;
            exp_rd_a.delete(); exp_wr_a.delete();
            exp_rd_b.delete(); exp_wr_b.delete();
         end
         if (cur_busy) busy_n++;
         if (cur_pe) pe_n++;
         if (cur_done) begin done_n++; done_cyc = cyc; end
      end
      if (rst_at > 0) begin
         chk("no_done_after_reset", done_n, 0);
         chk("idle_after_reset", cur_busy, 0);
      end else begin
         chk("done_cycle", done_cyc, dcyc);
         chk("done_pulses", done_n, 1);
         chk("busy_cycles", busy_n, dcyc);
         chk("pool_en_pulses", pe_n, 4 * nwin);
         chk("writes_pending", s ? exp_wr_b.size() : exp_wr_a.size(), 0);
         chk("reads_pending", s ? exp_rd_b.size() : exp_rd_a.size(), 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      start_s = 1'b0;
      sel = 1'b0;
      #1;
      chk_reset_outs("a_reset_outputs");
      sel = 1'b1;
      #1;
      chk_reset_outs("b_reset_outputs");
      sel = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);

      // ascending map: maxima 5, 7, 13, 15
      for (int i = 0; i < 256; i++) mem[i] = i;
      run_pass(1'b0, 0, 0);
      @(negedge clk);

      // negated map: maxima 0, -2, -8, -10; stray start mid-pass
      for (int i = 0; i < 256; i++) mem[i] = -i;
      run_pass(1'b0, 10, 0);
      @(negedge clk);

      // start held during DONE must not launch a new pass
      for (int i = 0; i < 256; i++) mem[i] = $signed($urandom);
      run_pass(1'b0, 25, 0);
      @(posedge clk); #1;
      chk("start_in_done_ignored", cur_busy, 0);
      @(negedge clk);

      // back-to-back: second pass started in the first IDLE cycle after DONE
      run_pass(1'b0, 0, 0);
      run_pass(1'b0, 0, 0);
      @(negedge clk);

      // reset in cycle 8, then a clean pass
      for (int i = 0; i < 256; i++) mem[i] = $signed($urandom);
      run_pass(1'b0, 0, 8);
      @(negedge clk);
      run_pass(1'b0, 0, 0);
      @(negedge clk);

      // random maps on both geometries
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 256; i++) mem[i] = $signed($urandom);
         run_pass(p[0], 0, 0);
         @(negedge clk);
      end
      for (int i = 0; i < 256; i++) mem[i] = i;
      run_pass(1'b1, 0, 0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
